world_writeback: RTL



---
 rtl/world_pkg.sv | 23 ++
 rtl/world_cell_update.sv | 28 ++
 rtl/world_writeback.sv | 133 +++++++++++++
 3 files changed

// File: rtl/world_pkg.sv
// Shared types and default field widths for the world write-back sequencer.
package world_pkg;

    localparam int SIGNAL_BITS = 8;
    localparam int SUGAR_BITS  = 8;
    localparam logic [SIGNAL_BITS-1:0] DEPOSIT_DEFAULT = 8'd32;

    // One world RAM word: sugar in the upper field, pheromone in the lower.
    typedef struct packed {
        logic [SUGAR_BITS-1:0]  sugar;
        logic [SIGNAL_BITS-1:0] signal;
    } cell_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } wb_state_t;

endpackage

// File: rtl/world_cell_update.sv
// Combinational cell update: saturating pheromone deposit and sugar removal.
module world_cell_update
    import world_pkg::*;
#(
    parameter logic [SIGNAL_BITS-1:0] DEPOSIT = DEPOSIT_DEFAULT
) (
    input  cell_t cell_in,
    input  logic  collecting,
    input  logic  carrying,
    output cell_t cell_out
);

    logic [SIGNAL_BITS:0] sum;

    // Deposit with clamp at all-ones; take one sugar unless the cell is empty.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        cell_out = cell_in;
        sum      = {1'b0, cell_in.signal} + {1'b0, DEPOSIT};
        if (collecting || carrying) begin
            cell_out.signal = sum[SIGNAL_BITS] ? '1 : sum[SIGNAL_BITS-1:0];
        end
        if (collecting && (cell_in.sugar != '0)) begin
            cell_out.sugar = cell_in.sugar - SUGAR_BITS'(1);
        end
    end

endmodule

// File: rtl/world_writeback.sv
// Walks every ant after a move and read-modify-writes its world RAM cell.
module world_writeback
    import world_pkg::*;
#(
    parameter int NUM_ANTS    = 16,
    parameter int X_bits      = 8,
    parameter int Y_bits      = 8,
    parameter int SIGNAL_bits = SIGNAL_BITS,
    parameter int SUGAR_bits  = SUGAR_BITS,
    parameter logic [SIGNAL_BITS-1:0] DEPOSIT = DEPOSIT_DEFAULT
) (
    input  logic                             Clk,
    input  logic                             RESET_N,
    input  logic                             start,
    input  logic [NUM_ANTS*X_bits-1:0]       ant_X,
    input  logic [NUM_ANTS*Y_bits-1:0]       ant_Y,
    input  logic [NUM_ANTS-1:0]              ant_mouthFull,
    input  logic [NUM_ANTS-1:0]              ant_collecting,
    input  logic [NUM_ANTS-1:0]              ant_dropping,
    output logic [X_bits+Y_bits-1:0]         mem_addr,
    output logic                             mem_rd_en,
    input  logic [SUGAR_bits+SIGNAL_bits-1:0] mem_rd_data,
    output logic                             mem_wr_en,
    output logic [SUGAR_bits+SIGNAL_bits-1:0] mem_wr_data,
    output logic                             busy,
    output logic                             global_writing_flag,
    output logic [15:0]                      sugar_delivered
);

    localparam int IDX_W = (NUM_ANTS > 1) ? $clog2(NUM_ANTS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ANTS - 1);

    wb_state_t state, next_state;
    logic [IDX_W-1:0] idx;

    logic [NUM_ANTS*X_bits-1:0] snap_x;
    logic [NUM_ANTS*Y_bits-1:0] snap_y;
    logic [NUM_ANTS-1:0]        snap_full;
    logic [NUM_ANTS-1:0]        snap_coll;
    logic [NUM_ANTS-1:0]        snap_drop;

    cell_t cell_q;
    cell_t cell_next;
    logic  cur_active;

    assign cur_active = snap_full[idx] | snap_coll[idx];

    world_cell_update #(.DEPOSIT(DEPOSIT)) u_update (
        .cell_in    (cell_q),
        .collecting (snap_coll[idx]),
        .carrying   (snap_full[idx]),
        .cell_out   (cell_next)
    );

    // Written word is only meaningful while the write strobe is up.
    assign mem_wr_data = mem_wr_en ? cell_next : '0;

    // State register with synchronous abort back to IDLE.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!RESET_N) state <= ST_IDLE;
        else          state <= next_state;
    end

    // Next-state logic for the per-ant walk.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (start) next_state = ST_SELECT;
            ST_SELECT: begin
                if (cur_active)       next_state = ST_READ;
                else if (idx == LAST) next_state = ST_DONE;
                else                  next_state = ST_SELECT;
            end
            ST_READ:   next_state = ST_WAIT;
            ST_WAIT:   next_state = ST_WRITE;
            ST_WRITE:  next_state = (idx == LAST) ? ST_DONE : ST_SELECT;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Snapshot, ant index, captured cell and delivered counter.
    always_ff @(posedge Clk) begin
        if (!RESET_N) begin
            idx             <= '0;
            snap_x          <= '0;
            snap_y          <= '0;
            snap_full       <= '0;
            snap_coll       <= '0;
            snap_drop       <= '0;
            cell_q          <= '0;
            sugar_delivered <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                snap_x    <= ant_X;
                snap_y    <= ant_Y;
                snap_full <= ant_mouthFull;
                snap_coll <= ant_collecting;
                snap_drop <= ant_dropping;
                idx       <= '0;
            end
            if (state == ST_SELECT) begin
                if (snap_drop[idx] && (sugar_delivered != 16'hFFFF)) begin
                    sugar_delivered <= sugar_delivered + 16'd1;
                end
                if (!cur_active && (idx != LAST)) idx <= idx + IDX_W'(1);
            end
            if (state == ST_WAIT) cell_q <= cell_t'(mem_rd_data);
            if (state == ST_WRITE && (idx != LAST)) idx <= idx + IDX_W'(1);
        end
    end

    // Registered strobes and address, decoded from the upcoming state.
    always_ff @(posedge Clk) begin
        if (!RESET_N) begin
            mem_rd_en           <= 1'b0;
            mem_wr_en           <= 1'b0;
            global_writing_flag <= 1'b0;
            busy                <= 1'b0;
            mem_addr            <= '0;
        end else begin
            mem_rd_en           <= (next_state == ST_READ);
            mem_wr_en           <= (next_state == ST_WRITE);
            global_writing_flag <= (next_state == ST_DONE);
            busy                <= (next_state != ST_IDLE);
            if (next_state == ST_READ) begin
                mem_addr <= {snap_y[idx*Y_bits +: Y_bits], snap_x[idx*X_bits +: X_bits]};
            end
        end
    end

endmodule
